// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Default operand, quotient and remainder width.
  localparam int unsigned DIV_W = 8;

  // Step counter width for the default build; it holds values 0..DIV_W.
  localparam int unsigned CNT_W = $clog2(DIV_W + 1);

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step. It shifts the next dividend bit into the partial remainder,
// makes a trial subtraction of the divisor, and keeps the difference only if it is not negative.
//
// The partial remainder is notionally WIDTH+1 bits wide. Between steps its top bit is always
// zero, because the kept remainder is always below the divisor or, for a zero divisor, below
// the dividend. For that reason only WIDTH bits are passed in and out.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_acc_i,
  input  logic [WIDTH-1:0] quo_sh_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_acc_o,
  output logic [WIDTH-1:0] quo_sh_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] trial;

  // Shift, then trial-subtract; the borrow (msb of trial) decides restore or keep.
  always_comb begin
    sh    = {rem_acc_i, quo_sh_i[WIDTH-1]};
    trial = sh - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_acc_o = trial[WIDTH-1:0];
      quo_sh_o  = {quo_sh_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_acc_o = sh[WIDTH-1:0];
      quo_sh_o  = {quo_sh_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div8_seq.sv
// Sequential restoring unsigned divider. It retires one quotient bit per clock and uses a
// start/busy/done handshake.
// Optional feature macro DIV8_DIVZ_EN: this adds the div_by_zero output. With it, an
// accepted start whose divisor is zero skips the iteration and finishes on the next cycle.
module div8_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV8_DIVZ_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quo_sh_q, quo_sh_d;
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV8_DIVZ_EN
  logic             div_by_zero_q, div_by_zero_d;
`endif

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             accept;
  logic             skip_run;
  logic             last_step;

  // A new operation is taken in any state except RUN.
  assign accept    = start && (state_q != StRun);
  assign last_step = (state_q == StRun) && (cnt_q == CntW'(1));

`ifdef DIV8_DIVZ_EN
  assign skip_run = accept && (divisor == '0);
`else
  assign skip_run = 1'b0;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_acc_i (rem_acc_q),
    .quo_sh_i  (quo_sh_q),
    .divisor_i (divisor_q),
    .rem_acc_o (step_rem),
    .quo_sh_o  (step_quo)
  );

  // State register; the synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StFin: begin
        if (accept) begin
          state_d = skip_run ? StFin : StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (last_step) begin
          state_d = StFin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded directly from the state.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StFin);
  end

  // Datapath next state: load on accept, iterate in RUN, capture results on entry to FIN.
  always_comb begin
    cnt_d         = cnt_q;
    divisor_d     = divisor_q;
    quo_sh_d      = quo_sh_q;
    rem_acc_d     = rem_acc_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
`ifdef DIV8_DIVZ_EN
    div_by_zero_d = div_by_zero_q;
`endif
    if (accept) begin
      divisor_d = divisor;
      quo_sh_d  = dividend;
      rem_acc_d = '0;
      cnt_d     = CntW'(WIDTH);
`ifdef DIV8_DIVZ_EN
      if (skip_run) begin
        quotient_d    = '1;
        remainder_d   = dividend;
        div_by_zero_d = 1'b1;
      end
`endif
    end else if (state_q == StRun) begin
      rem_acc_d = step_rem;
      quo_sh_d  = step_quo;
      cnt_d     = cnt_q - CntW'(1);
      if (last_step) begin
        quotient_d    = step_quo;
        remainder_d   = step_rem;
`ifdef DIV8_DIVZ_EN
        div_by_zero_d = 1'b0;
`endif
      end
    end
  end

  // Datapath registers; results clear on reset and otherwise hold between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      divisor_q     <= '0;
      quo_sh_q      <= '0;
      rem_acc_q     <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
`ifdef DIV8_DIVZ_EN
      div_by_zero_q <= 1'b0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      divisor_q     <= divisor_d;
      quo_sh_q      <= quo_sh_d;
      rem_acc_q     <= rem_acc_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
`ifdef DIV8_DIVZ_EN
      div_by_zero_q <= div_by_zero_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV8_DIVZ_EN
  assign div_by_zero = div_by_zero_q;
`endif

endmodule
